// File: rtl/led_pattern_arbiter.sv
// Round-robin arbiter for the shared status LED: grants one requester at a time
// and plays its on/off blink pattern, timed by a prescaled tick.
module led_pattern_arbiter #(
  parameter int NREQ     = 4,
  parameter int PRESCALE = 16000,
  parameter int CNT_W    = 8
) (
  input  logic                    pin3_clk_16mhz,
  input  logic                    pin4_reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   on_ticks,
  input  logic [NREQ*CNT_W-1:0]   off_ticks,
  input  logic [NREQ*4-1:0]       blinks,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    led
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PS_W  = $clog2(PRESCALE);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    owner_reg, owner_next;
  logic [IDX_W-1:0]    ptr_reg, ptr_next;
  logic [CNT_W-1:0]    on_reg, on_next;
  logic [CNT_W-1:0]    off_reg, off_next;
  logic [3:0]          remaining_reg, remaining_next;
  logic [PS_W-1:0]     presc_reg, presc_next;
  logic [CNT_W-1:0]    tick_cnt_reg, tick_cnt_next;
  logic [NREQ-1:0]     grant_reg, grant_next;
  logic [NREQ-1:0]     done_reg, done_next;
  logic                busy_reg, busy_next;
  logic                led_reg, led_next;

  logic [CNT_W-1:0]    on_arr     [NREQ];
  logic [CNT_W-1:0]    off_arr    [NREQ];
  logic [3:0]          blinks_arr [NREQ];

  logic                found;
  logic [IDX_W-1:0]    pick;
  logic                tick;
  logic [CNT_W-1:0]    on_last, off_last;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign on_arr[gi]     = on_ticks[gi*CNT_W +: CNT_W];
      assign off_arr[gi]    = off_ticks[gi*CNT_W +: CNT_W];
      assign blinks_arr[gi] = blinks[gi*4 +: 4];
    end
  endgenerate

  assign tick     = (presc_reg == PS_W'(PRESCALE - 1));
  // A zero duration behaves as one tick so the LED can never stick.
  assign on_last  = (on_reg  == '0) ? '0 : on_reg  - 1'b1;
  assign off_last = (off_reg == '0) ? '0 : off_reg - 1'b1;

  // Round-robin search starting just after the last owner.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_reg) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge pin3_clk_16mhz or negedge pin4_reset_n) begin
    if (!pin4_reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      ptr_reg       <= IDX_W'(NREQ - 1);
      on_reg        <= '0;
      off_reg       <= '0;
      remaining_reg <= '0;
      presc_reg     <= '0;
      tick_cnt_reg  <= '0;
      grant_reg     <= '0;
      done_reg      <= '0;
      busy_reg      <= 1'b0;
      led_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      ptr_reg       <= ptr_next;
      on_reg        <= on_next;
      off_reg       <= off_next;
      remaining_reg <= remaining_next;
      presc_reg     <= presc_next;
      tick_cnt_reg  <= tick_cnt_next;
      grant_reg     <= grant_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      led_reg       <= led_next;
    end
  end

  // Prescaler and tick counter default to zero, so every phase change clears them.
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    on_next        = on_reg;
    off_next       = off_reg;
    remaining_next = remaining_reg;
    presc_next     = '0;
    tick_cnt_next  = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          owner_next     = pick;
          on_next        = on_arr[pick];
          off_next       = off_arr[pick];
          remaining_next = blinks_arr[pick];
          state_next     = (blinks_arr[pick] == 4'd0) ? DONE : ON;
        end
      end
      ON: begin
        if (!req[owner_reg]) begin
          state_next = IDLE;
          ptr_next   = owner_reg;
        end else if (tick && (tick_cnt_reg == on_last)) begin
          state_next = OFF;
        end else begin
          presc_next    = tick ? '0 : presc_reg + 1'b1;
          tick_cnt_next = tick ? tick_cnt_reg + 1'b1 : tick_cnt_reg;
        end
      end
      OFF: begin
        if (!req[owner_reg]) begin
          state_next = IDLE;
          ptr_next   = owner_reg;
        end else if (tick && (tick_cnt_reg == off_last)) begin
          remaining_next = remaining_reg - 4'd1;
          state_next     = (remaining_reg == 4'd1) ? DONE : ON;
        end else begin
          presc_next    = tick ? '0 : presc_reg + 1'b1;
          tick_cnt_next = tick ? tick_cnt_reg + 1'b1 : tick_cnt_reg;
        end
      end
      DONE: begin
        state_next = IDLE;
        ptr_next   = owner_reg;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the upcoming state and then registered.
  always_comb begin
    grant_next = '0;
    done_next  = '0;
    busy_next  = (state_next != IDLE);
    led_next   = (state_next == ON);
    if (state_next == ON || state_next == OFF) grant_next = ONE << owner_next;
    if (state_next == DONE) done_next = ONE << owner_next;
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign busy  = busy_reg;
  assign led   = led_reg;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Directed and random stimulus for led_pattern_arbiter, checked every cycle
// against a grant-position model of the blink schedule.
module tb_led_pattern_arbiter;
  localparam int NREQ = 4, PRESCALE = 4, CNT_W = 8;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*CNT_W-1:0] on_ticks = '0, off_ticks = '0;
  logic [NREQ*4-1:0]     blinks = '0;
  logic [NREQ-1:0]       grant, done;
  logic                  busy, led;

  int checks = 0, errors = 0;

  // Model: mode 0 idle, 1 granted (m_t cycles into the grant), 2 done cycle.
  int m_mode, m_owner, m_last, m_t, m_on, m_off, m_bl;

  always #5 clk = ~clk;

  led_pattern_arbiter #(.NREQ(NREQ), .PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .pin3_clk_16mhz(clk), .pin4_reset_n(rst_n), .req(req),
    .on_ticks(on_ticks), .off_ticks(off_ticks), .blinks(blinks),
    .grant(grant), .done(done), .busy(busy), .led(led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_last = NREQ - 1; m_t = 0;
    m_on = 1; m_off = 1; m_bl = 0;
  endtask

  task automatic model_edge();
    bit got;
    int w, idx;
    got = 0; w = 0;
    case (m_mode)
      0: begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_last + 1 + k) % NREQ;
          if (!got && req[idx]) begin got = 1; w = idx; end
        end
        if (got) begin
          m_owner = w;
          m_on  = eff(int'(on_ticks[w*CNT_W +: CNT_W]));
          m_off = eff(int'(off_ticks[w*CNT_W +: CNT_W]));
          m_bl  = int'(blinks[w*4 +: 4]);
          m_t   = 0;
          m_mode = (m_bl == 0) ? 2 : 1;
        end
      end
      1: begin
        if (!req[m_owner]) begin
          m_mode = 0; m_last = m_owner;
          $display("abort: requester %0d after %0d cycles", m_owner, m_t + 1);
        end else begin
          m_t++;
          if (m_t == m_bl * (m_on + m_off) * PRESCALE) m_mode = 2;
        end
      end
      default: begin
        m_mode = 0; m_last = m_owner;
        $display("pattern done: requester %0d blinks %0d on %0d off %0d", m_owner, m_bl, m_on, m_off);
      end
    endcase
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] eg, ed;
    logic el;
    eg = (m_mode == 1) ? NREQ'(1 << m_owner) : '0;
    ed = (m_mode == 2) ? NREQ'(1 << m_owner) : '0;
    el = (m_mode == 1) && ((m_t % ((m_on + m_off) * PRESCALE)) < m_on * PRESCALE);
    check("model_grant", grant, eg);
    check("model_done", done, ed);
    check("model_led", led, el);
    check("model_busy", busy, m_mode != 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases off-edge.
  task automatic apply_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_led", led, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_fields(input int i, input int on, input int off, input int bl);
    on_ticks[i*CNT_W +: CNT_W] = CNT_W'(on);
    off_ticks[i*CNT_W +: CNT_W] = CNT_W'(off);
    blinks[i*4 +: 4] = 4'(bl);
  endtask

  initial begin
    int order[$];
    int lens[$];
    int len, led_hi;
    logic [NREQ-1:0] prev;
    logic [7:0] led_seq;

    model_reset();
    apply_reset();

    // Single request: on=2, off=1, blinks=3.
    set_fields(0, 2, 1, 3);
    req = 4'b0001;
    step();
    check("single_grant_T1", grant, 4'b0001);
    check("single_led_T1", led, 1);
    for (int c = 2; c <= 36; c++) step();
    check("single_led_T36", led, 0);
    step();
    check("single_done_T37", done, 4'b0001);
    req = 4'b0000;
    step();
    check("single_busy_T38", busy, 0);

    // Contention from reset: order 0,1,2,3,0 with 8-cycle grants.
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_fields(i, 1, 1, 1);
    req = 4'b1111;
    prev = '0; len = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (grant != 0 && prev == 0) begin
        for (int i = 0; i < NREQ; i++) if (grant[i]) order.push_back(i);
        len = 0;
      end
      if (grant != 0) len++;
      if (grant == 0 && prev != 0) lens.push_back(len);
      prev = grant;
    end
    req = 4'b0000;
    step(); step();
    check("cont_count", order.size(), 5);
    for (int k = 0; k < 5 && k < order.size(); k++) check("cont_order", order[k], k % NREQ);
    for (int k = 0; k < lens.size(); k++) check("cont_len", lens[k], 8);

    // Zero durations: 4 cycles on, 4 off.
    set_fields(0, 0, 0, 1);
    req = 4'b0001;
    led_seq = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      led_seq[c] = led;
    end
    check("zero_led_seq", led_seq, 8'h0F);
    step();
    check("zero_done", done, 4'b0001);
    req = 4'b0000;
    step();

    // blinks=0: immediate done, no grant, led low.
    set_fields(0, 3, 3, 0);
    req = 4'b0001;
    step();
    check("b0_done", done, 4'b0001);
    check("b0_grant", grant, 0);
    check("b0_led", led, 0);
    req = 4'b0000;
    step(); step();

    // Abort: req[2] drops in its 5th ON cycle, pending req[3] follows.
    set_fields(2, 3, 2, 2);
    set_fields(3, 1, 1, 1);
    req = 4'b1100;
    step();
    check("abort_grant2", grant, 4'b0100);
    for (int c = 0; c < 4; c++) step();
    req = 4'b1000;
    step();
    check("abort_grant0", grant, 0);
    check("abort_led0", led, 0);
    check("abort_nodone", done, 0);
    step();
    check("abort_grant3", grant, 4'b1000);
    req = 4'b0000;
    step(); step();

    // Input changes mid-grant do not alter the captured pattern.
    set_fields(0, 2, 2, 2);
    req = 4'b0001;
    led_hi = 0; len = 0;
    for (int c = 0; c < 34; c++) begin
      step();
      if (c == 5) set_fields(0, 9, 5, 7);
      if (led) led_hi++;
      if (grant[0]) len++;
      if (done[0]) req = 4'b0000;
    end
    check("chg_led_cycles", led_hi, 16);
    check("chg_grant_cycles", len, 32);

    // Reset mid-OFF, then arbitration restarts from req[0].
    set_fields(0, 1, 3, 2);
    set_fields(1, 1, 1, 1);
    req = 4'b0001;
    for (int c = 0; c < 6; c++) step();
    check("midoff_led", led, 0);
    req = 4'b1010;
    apply_reset();
    step();
    check("post_rst_grant", grant, 4'b0010);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < NREQ; i++)
          set_fields(i, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      step();
    end
    req = 4'b0000;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_arbiter.md
# led_pattern_arbiter

Shares the board's single status LED (pin13) between up to NREQ requesters, replacing the free-running counter drive. Each requester asks for the LED with its own blink pattern (on duration, off duration, blink count). The block grants the LED round-robin, plays the winner's pattern from a prescaled tick, and reports completion. It sits between on-chip status sources and the pin13 output.

## Interface
- NREQ, 4, number of requesters (2..8)
- PRESCALE, 16000, clock cycles per tick (1 ms at 16 MHz); minimum 2
- CNT_W, 8, width of the on/off duration fields, in ticks
- pin3_clk_16mhz  in  1  single clock, rising edge
- pin4_reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  level request per requester; held high until done or abort
- on_ticks  in  NREQ*CNT_W  per-requester LED-on duration; field i at [i*CNT_W +: CNT_W]
- off_ticks  in  NREQ*CNT_W  per-requester LED-off duration; same packing
- blinks  in  NREQ*4  per-requester blink count (0..15); field i at [i*4 +: 4]
- grant  out  NREQ  one-hot; owner of the LED
- done  out  NREQ  one-cycle pulse on the owner's bit when its pattern completes
- busy  out  1  high whenever the state is not IDLE
- led  out  1  drives pin13

## Operation
- The states are IDLE, ON, OFF and DONE. All outputs are registered.
- Reset values: state IDLE, grant 0, done 0, busy 0, led 0, prescaler 0, and the round-robin pointer set so that req[0] has the highest priority.
- Round-robin: search starts at index (last_winner+1) mod NREQ. The pointer updates only when a grant ends, whether by completion or by abort.
- IDLE with any req high: pick the winner and capture its on, off and blinks fields into internal registers. Later changes to the inputs are ignored until the next grant.
  - If blinks=0, go to DONE.
  - Otherwise go to ON, set grant[w]=1, clear the prescaler and load remaining=blinks.
- ON: led=1. After max(on,1) ticks, go to OFF.
- OFF: led=0. After max(off,1) ticks, decrement remaining.
  - If remaining is now 0, go to DONE.
  - Otherwise go to ON with the prescaler cleared.
- DONE: lasts one cycle. done[w]=1, grant=0, led=0, pointer updated, then go to IDLE.
- Abort: if req[w] is low in any cycle in ON or OFF, the next cycle is IDLE with grant=0 and led=0. done is not pulsed and the pointer is updated.
- Tick generation:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - A tick occurs on the wrap.
  - The prescaler is cleared on every entry to ON or OFF, so each phase is exactly N*PRESCALE cycles.
- Duration fields are unsigned. A value of 0 is treated as 1, so the LED is never stuck.
- The tick counter per phase is CNT_W bits and compares for equality against the effective duration minus 1. Wrap-around is not possible.

## Timing
- Grant latency: req rises in cycle T while in IDLE. grant and led are high at T+1. A req that is already high when DONE exits is sampled in the IDLE cycle that follows.
- A phase entered at cycle S lasts exactly D*PRESCALE cycles: cycles S through S+D*PRESCALE-1.
- Total grant length for a completed pattern: blinks*(on+off)*PRESCALE cycles, then one DONE cycle, then at least one IDLE cycle before the next grant.
- blinks=0: grant stays low, the led does not change, and done pulses at T+1.
- Simultaneous requests: exactly one grant. Losers stay pending, with no starvation, and wait at most NREQ-1 full patterns.
- A req that rises while busy waits. A req that drops while pending and not granted is simply ignored.
- Reset asserted mid-pattern: all outputs go to their reset values immediately (asynchronously). After reset release, arbitration restarts from req[0].

## Test plan
Every scenario uses PRESCALE=4.
- Single request: req[0]=1 with on=2, off=1, blinks=3 drops at the done pulse.
  - grant[0] is high at T+1, and led is high for 8 cycles then low for 4, three times (36 cycles).
  - done[0] pulses at T+37, and busy is low at T+38.
- Contention: req=4'b1111 held, with blinks=1, on=1, off=1 for all.
  - Grants are issued in order 0,1,2,3,0.
  - Each grant lasts 8 cycles, separated by one DONE cycle and one IDLE cycle.
- Zero fields:
  - on=0, off=0, blinks=1: led is high for 4 cycles and low for 4.
  - blinks=0: done pulses at T+1 with led=0 throughout.
- Abort: req[2] drops in the 5th cycle of ON.
  - The next cycle has grant=0 and led=0, with no done pulse.
  - A pending req[3] is granted 2 cycles later.
- Input changes during a grant: on_ticks[0] changes mid-pattern and the pattern timing is unchanged.
- Reset mid-OFF: pin4_reset_n low makes led, grant, busy and done 0 within the same cycle. After release, req=4'b1010 grants req[1] first.
